// File: rtl/fifo_fwft_prog_flags.sv
// First-word-fall-through FIFO with registered head word, programmable full/empty
// flags with hysteresis, and single-cycle overflow/underflow pulses.
module fifo_fwft_prog_flags #(
    parameter int C_DATA_WIDTH  = 128,
    parameter int C_FIFO_DEPTH  = 16,
    parameter int C_COUNT_WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wren,
    input  logic [C_DATA_WIDTH-1:0]  datain,
    input  logic                     rden,
    output logic [C_DATA_WIDTH-1:0]  dataout,
    output logic                     empty,
    output logic                     full,
    input  logic [C_COUNT_WIDTH-1:0] pf_assert,
    input  logic [C_COUNT_WIDTH-1:0] pf_negate,
    input  logic [C_COUNT_WIDTH-1:0] pe_thresh,
    output logic                     prog_full,
    output logic                     prog_empty,
    output logic                     overflow,
    output logic                     underflow,
    output logic [C_COUNT_WIDTH-1:0] count
);

    localparam int DEPTH = (C_FIFO_DEPTH < 2) ? 2 : C_FIFO_DEPTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [C_DATA_WIDTH-1:0]  mem_r [DEPTH];
    logic [C_DATA_WIDTH-1:0]  dataout_r;
    logic [AW-1:0]            wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
    logic [CW-1:0]            count_r, count_nxt_s, count_after_rd_s;
    logic [C_COUNT_WIDTH-1:0] count_ext_s;
    logic                     write_ok_s, read_ok_s, empty_nxt_s, prog_full_nxt_s;
    logic                     empty_r, full_r, prog_full_r, prog_empty_r;
    logic                     overflow_r, underflow_r;

    // Accept decisions, pointer advance, next occupancy and next flag values
    always_comb begin
        write_ok_s  = wren & ~full_r & ~flush;
        read_ok_s   = rden & ~empty_r & ~flush;
        wptr_nxt_s  = wptr_r;
        rptr_nxt_s  = rptr_r;
        if (write_ok_s) begin
            wptr_nxt_s = (wptr_r == LAST_PTR) ? {AW{1'b0}} : wptr_r + AW'(1);
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (read_ok_s) begin
            rptr_nxt_s = (rptr_r == LAST_PTR) ? {AW{1'b0}} : rptr_r + AW'(1);
        end else begin
            rptr_nxt_s = rptr_r;
        end
        count_after_rd_s = read_ok_s ? (count_r - CW'(1)) : count_r;
        count_nxt_s      = write_ok_s ? (count_after_rd_s + CW'(1)) : count_after_rd_s;
        // A head word landing in storage on this edge is not yet visible: hold empty one cycle
        empty_nxt_s = (count_nxt_s == {CW{1'b0}}) ||
                      (write_ok_s && (count_after_rd_s == {CW{1'b0}}));
        count_ext_s = C_COUNT_WIDTH'(count_nxt_s);
        if (count_ext_s >= pf_assert) begin
            prog_full_nxt_s = 1'b1;
        end else if (count_ext_s <= pf_negate) begin
            prog_full_nxt_s = 1'b0;
        end else begin
            prog_full_nxt_s = prog_full_r;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (write_ok_s && !rst) begin
            mem_r[wptr_r] <= datain;
        end
    end

    // Head word register, refreshed every cycle from the next read position
    always_ff @(posedge clk) begin
        dataout_r <= mem_r[rptr_nxt_s];
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr_r       <= {AW{1'b0}};
            rptr_r       <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            empty_r      <= 1'b1;
            full_r       <= 1'b0;
            prog_full_r  <= 1'b0;
            prog_empty_r <= 1'b1;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            wptr_r       <= wptr_nxt_s;
            rptr_r       <= rptr_nxt_s;
            count_r      <= count_nxt_s;
            empty_r      <= empty_nxt_s;
            full_r       <= (count_nxt_s == DEPTH_CNT);
            prog_full_r  <= prog_full_nxt_s;
            prog_empty_r <= (count_ext_s <= pe_thresh);
            overflow_r   <= wren & full_r;
            underflow_r  <= rden & empty_r;
        end
    end

    assign dataout    = dataout_r;
    assign empty      = empty_r;
    assign full       = full_r;
    assign prog_full  = prog_full_r;
    assign prog_empty = prog_empty_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;
    assign count      = C_COUNT_WIDTH'(count_r);

endmodule
